// File: rtl/btn_macro_player.sv
// btn_macro_player
//
// Records a short list of button-press vectors and replays them as an
// emulated debounced, active-low button bank for the calculator. Each stored
// entry is held low for HOLD cycles, then released for GAP cycles. A zero
// entry therefore acts as a pure delay step.
//
// Optional build macro:
//   BTN_MACRO_LOOP_EN - adds i_loop; when high at the end of the final GAP,
//                       playback restarts from entry 0 with no idle cycle.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous reset, active-high (sequence is lost)
//   i_wr_en    append i_wr_data to the sequence (idle only, dropped when full)
//   i_wr_data  press vector, bit=1 means button pressed
//   i_play     start playback of the stored sequence
//   i_clear    empty the sequence, aborting any playback in progress
//   i_loop     (BTN_MACRO_LOOP_EN only) repeat playback continuously
//   o_btn      emulated buttons, active-low, all-ones when released
//   o_event    one-cycle active-high press pulse on the first held cycle
//   o_busy     playback in progress
//   o_done     one-cycle pulse on the first idle cycle after playback
//   o_full     sequence storage is full
//   o_count    number of stored entries

module btn_macro_player #(
  parameter int N_BTN = 11,
  parameter int DEPTH = 16,
  parameter int HOLD  = 4,
  parameter int GAP   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [N_BTN-1:0]           i_wr_data,
  input  logic                       i_play,
  input  logic                       i_clear,
`ifdef BTN_MACRO_LOOP_EN
  input  logic                       i_loop,
`endif
  output logic [N_BTN-1:0]           o_btn,
  output logic [N_BTN-1:0]           o_event,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_T = (HOLD > GAP) ? HOLD : GAP;
  localparam int TMR_W = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             done;
  logic             mem_we;
  logic             last_entry;
  logic             loop;
  logic [N_BTN-1:0] entry;
  logic [N_BTN-1:0] mem [DEPTH];

`ifdef BTN_MACRO_LOOP_EN
  assign loop = i_loop;
`else
  assign loop = 1'b0;
`endif

  // Clear wins in every state; a write only lands when idle, not masked by
  // a simultaneous play, and there is room left.
  always_comb begin
    mem_we     = 1'b0;
    count_next = count;
    if (i_clear) begin
      count_next = '0;
    end else if (state == ST_IDLE && !i_play && i_wr_en && !full) begin
      mem_we     = 1'b1;
      count_next = count + 1'b1;
    end
  end

  assign last_entry = ((CNT_W'(idx) + 1'b1) == count);

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[count[IDX_W-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      timer <= '0;
      count <= '0;
      full  <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!i_clear && i_play) begin
            if (count != '0) begin
              state <= ST_PRESS;
              idx   <= '0;
              timer <= '0;
            end else begin
              // Playing an empty sequence completes immediately.
              done <= 1'b1;
            end
          end
        end
        ST_PRESS: begin
          if (i_clear) begin
            state <= ST_IDLE;
          end else if (timer == HOLD_LAST) begin
            state <= ST_GAP;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_GAP: begin
          if (i_clear) begin
            state <= ST_IDLE;
          end else if (timer == GAP_LAST) begin
            timer <= '0;
            if (!last_entry) begin
              idx   <= idx + 1'b1;
              state <= ST_PRESS;
            end else if (loop) begin
              idx   <= '0;
              state <= ST_PRESS;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state so a press shows up in
  // the cycle right after the edge that entered PRESS.
  assign entry   = mem[idx];
  assign o_btn   = (state == ST_PRESS) ? ~entry : '1;
  assign o_event = (state == ST_PRESS && timer == '0) ? entry : '0;
  assign o_busy  = (state != ST_IDLE);
  assign o_done  = done;
  assign o_full  = full;
  assign o_count = count;

endmodule
